// File: rtl/sys_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sys_cmd_pkg
// Shared definitions for the UART register/ALU command protocol. The host
// command master, the system controller and the benches all use this package.
//   - command-type encodings (cmd_type_e)
//   - frame opcodes (first byte of every frame)
//   - host FSM state codes
//   - frame length / response length per command type
// -----------------------------------------------------------------------------
package sys_cmd_pkg;

  // Command type as carried on cmd_type.
  typedef enum logic [1:0] {
    CT_RF_WR   = 2'd0,
    CT_RF_RD   = 2'd1,
    CT_ALU_OP  = 2'd2,
    CT_ALU_NOP = 2'd3
  } cmd_type_e;

  // Opcode byte that opens each frame on the link.
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Host FSM state codes, kept as plain constants so legacy code that
  // compares raw state bits keeps working.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // Number of bytes the host transmits for a command type.
  function automatic logic [2:0] frame_len(input cmd_type_e t);
    frame_len = 3'd2;
    case (t)
      CT_RF_WR:  frame_len = 3'd3;
      CT_RF_RD:  frame_len = 3'd2;
      CT_ALU_OP: frame_len = 3'd4;
      default:   frame_len = 3'd2;
    endcase
  endfunction

  // Number of response bytes the far end returns for a command type.
  function automatic logic [1:0] rsp_len(input cmd_type_e t);
    rsp_len = 2'd2;
    case (t)
      CT_RF_WR: rsp_len = 2'd0;
      CT_RF_RD: rsp_len = 2'd1;
      default:  rsp_len = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/sys_host_cmd_if.sv
// -----------------------------------------------------------------------------
// sys_host_cmd_if
// Bundles the three handshakes of the host command master:
//   command request : cmd_valid/cmd_ready + cmd_type/addr/data_a/data_b/fun
//   byte TX         : tx_data/tx_valid/tx_ready
//   byte RX         : rx_data/rx_valid (one-cycle pulse per byte)
//   response        : rsp_valid/rsp_data/rsp_timeout, plus busy
// modport master : the command master itself (sys_host_cmd)
// modport slave  : whatever sits around it (command source, UART, bench)
// -----------------------------------------------------------------------------
interface sys_host_cmd_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_type;
  logic [RF_ADDR-1:0]      cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data_a;
  logic [DATA_WIDTH-1:0]   cmd_data_b;
  logic [3:0]              cmd_fun;

  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_valid;

  logic                    rsp_valid;
  logic [2*DATA_WIDTH-1:0] rsp_data;
  logic                    rsp_timeout;
  logic                    busy;

  modport master (
    input  cmd_valid, cmd_type, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun,
    input  tx_ready, rx_data, rx_valid,
    output cmd_ready, tx_data, tx_valid,
    output rsp_valid, rsp_data, rsp_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun,
    output tx_ready, rx_data, rx_valid,
    input  cmd_ready, tx_data, tx_valid,
    input  rsp_valid, rsp_data, rsp_timeout, busy
  );

endinterface

// File: rtl/sys_cmd_timer.sv
// -----------------------------------------------------------------------------
// sys_cmd_timer
// Loadable / clearable up-counter with a terminal-count flag, used as the
// response-timeout timer of the host command master.
// Ports:
//   CLK, RST     clock, asynchronous active-low reset (count -> 0)
//   i_clr        synchronous clear to 0 (highest priority)
//   i_load       synchronous load of i_load_val
//   i_load_val   value loaded by i_load
//   i_inc        count up by one
//   o_tc         count equals TC_VAL
// -----------------------------------------------------------------------------
module sys_cmd_timer #(
  parameter int                   TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TC_VAL    = '1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [TIMEOUT_W-1:0] i_load_val,
  input  logic                 i_inc,
  output logic                 o_tc
);

  logic [TIMEOUT_W-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/sys_host_cmd.sv
// -----------------------------------------------------------------------------
// sys_host_cmd
// Host-side command master for the UART register/ALU protocol. Accepts one
// command, serialises it into frame bytes on the TX byte interface, collects
// the response bytes from the RX byte interface and reports the assembled
// result (or a timeout) with a one-cycle rsp_valid pulse.
// Ports:
//   CLK            clock
//   RST            asynchronous active-low reset
//   bus (master)   command request, TX bytes, RX bytes, response, busy
// Frames (link order):
//   RF_WR  : AA, addr, data        -> no response
//   RF_RD  : BB, addr              -> 1 byte  (rsp_data[7:0])
//   ALU_OP : CC, A, B, fun         -> 2 bytes (LSB first)
//   ALU_NOP: DD, fun               -> 2 bytes (LSB first)
// -----------------------------------------------------------------------------
module sys_host_cmd
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RF_ADDR     = 4,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic            CLK,
  input logic            RST,
  sys_host_cmd_if.master bus
);

  // Registered command and transaction state.
  logic [1:0]              r_state;
  cmd_type_e               r_type;
  logic [RF_ADDR-1:0]      r_addr;
  logic [DATA_WIDTH-1:0]   r_data_a;
  logic [DATA_WIDTH-1:0]   r_data_b;
  logic [3:0]              r_fun;
  logic [1:0]              r_idx;      // byte index inside the frame
  logic [1:0]              r_rx_cnt;   // response bytes received so far
  logic                    r_timeout;  // last transaction ended by timeout
  logic [2*DATA_WIDTH-1:0] r_rsp_data;

  logic [DATA_WIDTH-1:0]   w_frame_byte;
  logic [1:0]              w_last_idx;
  logic [1:0]              w_rsp_len;
  logic [1:0]              w_rx_cnt_nxt;
  logic                    w_accept;
  logic                    w_tx_fire;
  logic                    w_rx_take;
  logic                    w_tmr_clr;
  logic                    w_tmr_inc;
  logic                    w_tmr_tc;

  assign w_last_idx   = 2'(frame_len(r_type) - 3'd1);
  assign w_rsp_len    = rsp_len(r_type);
  assign w_rx_cnt_nxt = r_rx_cnt + 2'd1;
  assign w_accept     = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_tx_fire    = (r_state == ST_SEND) && bus.tx_ready;
  assign w_rx_take    = (r_state == ST_WAIT_RSP) && bus.rx_valid;

  // The timer only runs while waiting for a response; it is held at 0
  // everywhere else so entering WAIT_RSP always starts from 0. A received
  // byte clears it even on the terminal-count cycle (the byte wins).
  assign w_tmr_clr = (r_state != ST_WAIT_RSP) || bus.rx_valid;
  assign w_tmr_inc = (r_state == ST_WAIT_RSP) && !bus.rx_valid && !w_tmr_tc;

  sys_cmd_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .TC_VAL    (TIMEOUT_W'(TIMEOUT_CYC - 1))
  ) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .i_clr      (w_tmr_clr),
    .i_load     (1'b0),
    .i_load_val ({TIMEOUT_W{1'b0}}),
    .i_inc      (w_tmr_inc),
    .o_tc       (w_tmr_tc)
  );

  // Frame byte selected by the registered command type and byte index.
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no
    // latch is inferred.
    w_frame_byte = '0;
    case (r_type)
      CT_RF_WR: begin
        case (r_idx)
          2'd0:    w_frame_byte = DATA_WIDTH'(CMD_RF_WR);
          2'd1:    w_frame_byte = DATA_WIDTH'(r_addr);
          2'd2:    w_frame_byte = r_data_a;
          default: w_frame_byte = '0;
        endcase
      end
      CT_RF_RD: begin
        case (r_idx)
          2'd0:    w_frame_byte = DATA_WIDTH'(CMD_RF_RD);
          2'd1:    w_frame_byte = DATA_WIDTH'(r_addr);
          default: w_frame_byte = '0;
        endcase
      end
      CT_ALU_OP: begin
        case (r_idx)
          2'd0:    w_frame_byte = DATA_WIDTH'(CMD_ALU_OP);
          2'd1:    w_frame_byte = r_data_a;
          2'd2:    w_frame_byte = r_data_b;
          default: w_frame_byte = DATA_WIDTH'(r_fun);
        endcase
      end
      default: begin
        case (r_idx)
          2'd0:    w_frame_byte = DATA_WIDTH'(CMD_ALU_NOP);
          2'd1:    w_frame_byte = DATA_WIDTH'(r_fun);
          default: w_frame_byte = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the captured command fields are reset as well; they feed
      // tx_data through the frame mux and must never be X after reset.
      r_state    <= ST_IDLE;
      r_type     <= CT_RF_WR;
      r_addr     <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_fun      <= '0;
      r_idx      <= '0;
      r_rx_cnt   <= '0;
      r_timeout  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_type     <= cmd_type_e'(bus.cmd_type);
            r_addr     <= bus.cmd_addr;
            r_data_a   <= bus.cmd_data_a;
            r_data_b   <= bus.cmd_data_b;
            r_fun      <= bus.cmd_fun;
            r_idx      <= '0;
            r_rx_cnt   <= '0;
            r_timeout  <= 1'b0;
            r_rsp_data <= '0;
            r_state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (w_tx_fire) begin
            if (r_idx == w_last_idx) begin
              r_rx_cnt <= '0;
              r_state  <= (w_rsp_len == 2'd0) ? ST_DONE : ST_WAIT_RSP;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end

        ST_WAIT_RSP: begin
          if (w_rx_take) begin
            if (r_rx_cnt == 2'd0) begin
              r_rsp_data[DATA_WIDTH-1:0] <= bus.rx_data;
            end else begin
              r_rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.rx_data;
            end
            r_rx_cnt <= w_rx_cnt_nxt;
            if (w_rx_cnt_nxt == w_rsp_len) begin
              r_state <= ST_DONE;
            end
          end else if (w_tmr_tc) begin
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode straight from the state register so they follow
  // an asynchronous reset immediately.
  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.tx_valid    = (r_state == ST_SEND);
  assign bus.tx_data     = (r_state == ST_SEND) ? w_frame_byte : '0;
  assign bus.rsp_valid   = (r_state == ST_DONE);
  assign bus.rsp_timeout = (r_state == ST_DONE) && r_timeout;
  assign bus.rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_sys_host_cmd.sv
// -----------------------------------------------------------------------------
// tb_sys_host_cmd
// Bench for sys_host_cmd. Expected TX frame bytes and expected responses are
// queued when a command is issued and popped as the DUT transfers bytes and
// pulses rsp_valid. Inputs are driven and outputs sampled 1 time unit after
// the rising clock edge.
// -----------------------------------------------------------------------------
module tb_sys_host_cmd;
  import sys_cmd_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int TW   = 16;
  localparam int TCYC = 100;

  typedef struct {
    logic [2*DW-1:0] data;
    logic            timeout;
  } rsp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  sys_host_cmd_if #(.DATA_WIDTH(DW), .RF_ADDR(AW)) bus ();

  sys_host_cmd #(
    .DATA_WIDTH  (DW),
    .RF_ADDR     (AW),
    .TIMEOUT_W   (TW),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [DW-1:0]   exp_tx[$];
  rsp_t            exp_rsp[$];
  logic [2*DW-1:0] last_rsp = '0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one command, queues its expected frame bytes, and scrambles the
  // command fields after accept.
  task automatic issue(input logic [1:0] t, input logic [AW-1:0] addr,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] fun, input string name);
    int waitc = 0;
    while (bus.cmd_ready !== 1'b1 && waitc < 20) begin
      tick();
      waitc++;
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: cmd_ready=%b want 1", name, bus.cmd_ready);
    end
    bus.cmd_type   = t;
    bus.cmd_addr   = addr;
    bus.cmd_data_a = a;
    bus.cmd_data_b = b;
    bus.cmd_fun    = fun;
    bus.cmd_valid  = 1'b1;
    case (t)
      2'd0: begin
        exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr});
        exp_tx.push_back(a);
      end
      2'd1: begin
        exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr});
      end
      2'd2: begin
        exp_tx.push_back(8'hCC); exp_tx.push_back(a);
        exp_tx.push_back(b);     exp_tx.push_back({4'h0, fun});
      end
      default: begin
        exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fun});
      end
    endcase
    tick();
    bus.cmd_valid  = 1'b0;
    bus.cmd_type   = 2'($urandom);
    bus.cmd_addr   = 4'($urandom);
    bus.cmd_data_a = 8'($urandom);
    bus.cmd_data_b = 8'($urandom);
    bus.cmd_fun    = 4'($urandom);
    n_checks++;
    if ({bus.busy, bus.cmd_ready, bus.rsp_data} !== {1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL %s_accept: busy=%b cmd_ready=%b rsp_data=%h want 1 0 0000",
               name, bus.busy, bus.cmd_ready, bus.rsp_data);
    end
  endtask

  // Drains the expected TX bytes. mode 0: tx_ready held 1; mode 1: tx_ready
  // toggles 0/1 starting at 0. Returns right after the last transfer edge.
  task automatic pump_tx(input int mode, input string name);
    int            cyc  = 0;
    int            idle = 0;
    logic          hold = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] e;
    while (exp_tx.size() > 0 && cyc < 40) begin
      if (hold) begin
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== held) begin
          n_fail++;
          $display("FAIL %s_hold: tx_valid=%b tx_data=%h want 1 %h",
                   name, bus.tx_valid, bus.tx_data, held);
        end
      end
      bus.tx_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      if (bus.tx_valid === 1'b1) begin
        if (bus.tx_ready) begin
          e = exp_tx.pop_front();
          n_checks++;
          if (bus.tx_data !== e) begin
            n_fail++;
            $display("FAIL %s_txbyte: tx_data=%h want %h", name, bus.tx_data, e);
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = bus.tx_data;
        end
      end else begin
        idle++;
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_tx.size() > 0) begin
      n_fail++;
      $display("FAIL %s_txbudget: %0d bytes not sent want 0", name, exp_tx.size());
      exp_tx.delete();
    end
    if (mode == 0) begin
      n_checks++;
      if (idle != 0) begin
        n_fail++;
        $display("FAIL %s_txgap: %0d idle cycles want 0", name, idle);
      end
    end
    bus.tx_ready = 1'b0;
  endtask

  // Waits for rsp_valid (bounded), compares against the scoreboard and checks
  // the return to IDLE one cycle later. edges = clock edges waited.
  task automatic collect(input string name, input int budget, output int edges);
    rsp_t e;
    edges = 0;
    while (bus.rsp_valid !== 1'b1 && edges < budget) begin
      tick();
      edges++;
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || exp_rsp.size() == 0) begin
      n_fail++;
      $display("FAIL %s_rsp: rsp_valid=%b after %0d cycles, %0d expected queued",
               name, bus.rsp_valid, edges, exp_rsp.size());
      exp_rsp.delete();
    end else begin
      e = exp_rsp.pop_front();
      last_rsp = e.data;
      if ({bus.busy, bus.rsp_timeout, bus.rsp_data} !== {1'b1, e.timeout, e.data}) begin
        n_fail++;
        $display("FAIL %s_result: busy=%b timeout=%b data=%h want 1 %b %h",
                 name, bus.busy, bus.rsp_timeout, bus.rsp_data, e.timeout, e.data);
      end
    end
    tick();
    n_checks++;
    if ({bus.rsp_valid, bus.busy, bus.cmd_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s_idle: rsp_valid=%b busy=%b cmd_ready=%b want 0 0 1",
               name, bus.rsp_valid, bus.busy, bus.cmd_ready);
    end
  endtask

  task automatic send_rx(input logic [DW-1:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({bus.cmd_ready, bus.busy, bus.tx_valid, bus.rsp_valid, bus.rsp_timeout,
         bus.tx_data, bus.rsp_data} !== {5'b10000, 8'h00, 16'h0000}) begin
      n_fail++;
      $display("FAIL %s: rdy/busy/txv/rspv/to=%b%b%b%b%b tx=%h rsp=%h want 10000 00 0000",
               name, bus.cmd_ready, bus.busy, bus.tx_valid, bus.rsp_valid,
               bus.rsp_timeout, bus.tx_data, bus.rsp_data);
    end
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset_values");
    RST = 1'b1;
    tick();
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_rf_wr();
    int edges;
    exp_rsp.push_back('{16'h0000, 1'b0});
    issue(2'd0, 4'd3, 8'h5A, 8'h00, 4'h0, "rf_wr");
    pump_tx(0, "rf_wr");
    collect("rf_wr", 5, edges);
    n_checks++;
    if (edges != 0) begin
      n_fail++;
      $display("FAIL rf_wr_latency: rsp_valid %0d cycles late want 0", edges);
    end
  endtask

  task automatic test_alu_op();
    int edges;
    exp_rsp.push_back('{16'h0030, 1'b0});
    issue(2'd2, 4'd0, 8'h10, 8'h20, 4'h0, "alu_op");
    pump_tx(1, "alu_op");
    repeat (2) tick();
    send_rx(8'h30);
    repeat (3) tick();
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL alu_op_wait: rsp_valid=%b busy=%b want 0 1", bus.rsp_valid, bus.busy);
    end
    send_rx(8'h00);
    collect("alu_op", 5, edges);
  endtask

  task automatic test_alu_nop_timeout();
    int edges;
    exp_rsp.push_back('{16'h00EE, 1'b1});
    issue(2'd3, 4'd0, 8'h00, 8'h00, 4'h5, "alu_nop");
    pump_tx(0, "alu_nop");
    repeat (4) tick();
    send_rx(8'hEE);
    collect("alu_nop", 3 * TCYC, edges);
    n_checks++;
    if (edges != TCYC) begin
      n_fail++;
      $display("FAIL alu_nop_timeout_delay: rsp_valid %0d cycles after byte want %0d",
               edges, TCYC);
    end
  endtask

  task automatic test_coincident();
    int edges;
    exp_rsp.push_back('{16'hA75C, 1'b0});
    issue(2'd2, 4'd0, 8'h07, 8'h09, 4'h1, "coinc");
    pump_tx(0, "coinc");
    // Byte sampled on the cycle the timer sits at its terminal count.
    repeat (TCYC - 1) tick();
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL coinc_pre: rsp_valid=%b busy=%b want 0 1", bus.rsp_valid, bus.busy);
    end
    send_rx(8'h5C);
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL coinc_no_timeout: rsp_valid=%b busy=%b want 0 1",
               bus.rsp_valid, bus.busy);
    end
    repeat (TCYC - 40) tick();
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL coinc_restart: rsp_valid=%b busy=%b want 0 1", bus.rsp_valid, bus.busy);
    end
    send_rx(8'hA7);
    collect("coinc", 5, edges);
  endtask

  task automatic test_rf_rd();
    int edges;
    exp_rsp.push_back('{16'h0081, 1'b0});
    issue(2'd1, 4'd2, 8'h00, 8'h00, 4'h0, "rf_rd");
    pump_tx(0, "rf_rd");
    repeat (10) tick();
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL rf_rd_wait: rsp_valid=%b busy=%b want 0 1", bus.rsp_valid, bus.busy);
    end
    send_rx(8'h81);
    collect("rf_rd", 5, edges);
  endtask

  task automatic test_stray_and_reset();
    int edges;
    // Stray byte while idle must change nothing.
    send_rx(8'h77);
    n_checks++;
    if ({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_data} !== {3'b100, last_rsp}) begin
      n_fail++;
      $display("FAIL stray_rx: rdy=%b busy=%b rspv=%b data=%h want 1 0 0 %h",
               bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_data, last_rsp);
    end
    // Reset while the second ALU_OP byte is on the bus.
    bus.tx_ready = 1'b1;
    issue(2'd2, 4'd0, 8'h3C, 8'h4D, 4'h2, "rst_mid");
    n_checks++;
    if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hCC}) begin
      n_fail++;
      $display("FAIL rst_mid_byte0: tx_valid=%b tx_data=%h want 1 cc", bus.tx_valid, bus.tx_data);
    end
    tick();
    n_checks++;
    if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL rst_mid_byte1: tx_valid=%b tx_data=%h want 1 3c", bus.tx_valid, bus.tx_data);
    end
    RST = 1'b0;
    #1;
    check_idle_outputs("rst_mid_async");
    exp_tx.delete();
    bus.tx_ready = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    tick();
    exp_rsp.push_back('{16'h00C3, 1'b0});
    issue(2'd1, 4'd9, 8'h00, 8'h00, 4'h0, "rf_rd_after_rst");
    pump_tx(0, "rf_rd_after_rst");
    repeat (2) tick();
    send_rx(8'hC3);
    collect("rf_rd_after_rst", 5, edges);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_type   = 2'd0;
    bus.cmd_addr   = '0;
    bus.cmd_data_a = '0;
    bus.cmd_data_b = '0;
    bus.cmd_fun    = '0;
    bus.tx_ready   = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;

    test_reset();
    test_rf_wr();
    test_alu_op();
    test_alu_nop_timeout();
    test_coincident();
    test_rf_rd();
    test_stray_and_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sys_host_cmd.md
Name: sys_host_cmd

Overview:
Host-side command master for the UART register/ALU command protocol: the other end of the system controller.
- Takes one command request per transaction, serialises it into protocol bytes on a byte-wide TX interface, then collects the response bytes from a byte-wide RX interface.
- Returns the assembled result, or a timeout flag.
- Used in the host FPGA / test harness on the far side of the UART link, and as the protocol model in system-level benches.

Parameters:
DATA_WIDTH, 8, byte width of TX/RX data and operands
RF_ADDR, 4, register-file address width
TIMEOUT_W, 16, width of the response-timeout counter
TIMEOUT_CYC, 50000, idle cycles allowed between response bytes before timeout

Ports:
CLK  in  1  single clock
RST  in  1  asynchronous active-low reset
cmd_valid  in  1  command request valid
cmd_ready  out  1  high in IDLE only; command accepted on cmd_valid & cmd_ready
cmd_type  in  2  0=RF_WR, 1=RF_RD, 2=ALU_OP (with operands), 3=ALU_NOP (no operands)
cmd_addr  in  RF_ADDR  register address (RF_WR/RF_RD)
cmd_data_a  in  DATA_WIDTH  write data (RF_WR) or operand A (ALU_OP)
cmd_data_b  in  DATA_WIDTH  operand B (ALU_OP)
cmd_fun  in  4  ALU function (ALU_OP/ALU_NOP)
tx_data  out  DATA_WIDTH  byte to transmit
tx_valid  out  1  byte valid; byte transferred on tx_valid & tx_ready
tx_ready  in  1  UART TX side can take a byte
rx_data  in  DATA_WIDTH  received byte
rx_valid  in  1  one-cycle pulse per received byte
rsp_valid  out  1  one-cycle pulse: transaction complete
rsp_data  out  2*DATA_WIDTH  result; RF_RD in [7:0], ALU result LSB byte first on the link
rsp_timeout  out  1  qualifies rsp_valid: response incomplete
busy  out  1  high from command accept until the rsp_valid cycle inclusive

Behaviour:
- Reset values: tx_data, rsp_data and the timeout counter are 0; tx_valid, rsp_valid, rsp_timeout and busy are 0; cmd_ready is 1; FSM is IDLE.
- Frames (byte order on the link):
  - RF_WR: 0xAA, {0,addr}, data. 3 bytes, no response.
  - RF_RD: 0xBB, {0,addr}. 2 bytes, 1 response byte.
  - ALU_OP: 0xCC, A, B, {0,fun}. 4 bytes, 2 response bytes.
  - ALU_NOP: 0xDD, {0,fun}. 2 bytes, 2 response bytes.
- Command fields are registered at accept; later changes on cmd_* have no effect.
- FSM IDLE -> SEND -> WAIT_RSP -> DONE -> IDLE.
  - SEND holds byte index idx (0..3). tx_valid=1 and tx_data=frame[idx] are held stable until the transfer cycle. idx increments on transfer.
  - The first byte is presented the cycle after accept. Back-to-back transfers are allowed, 1 byte per cycle when tx_ready stays high.
  - After the last byte transfers: RF_WR goes to DONE; all other types go to WAIT_RSP with counter=0 and received count=0.
- WAIT_RSP:
  - Each rx_valid stores rx_data: byte 0 -> rsp_data[7:0], byte 1 -> rsp_data[15:8]. Each byte clears the counter.
  - When the expected count is reached, go to DONE.
  - Otherwise the counter increments every cycle without rx_valid. When it reaches TIMEOUT_CYC-1 with no rx_valid, go to DONE with the timeout flag set.
  - rx_valid and the terminal count in the same cycle: the byte wins and the counter clears.
- DONE (1 cycle): rsp_valid=1; rsp_timeout=flag; busy=1. Next state IDLE, where cmd_ready=1 again.
  - RF_WR: rsp_data=0.
  - RF_RD: rsp_data[15:8]=0.
  - On timeout: rsp_data holds the bytes captured so far, unreceived bytes 0.
- rsp_data holds its value until the next accept, which clears it to 0.
- rx_valid outside WAIT_RSP is ignored: no state change, no data capture.
- Reset mid-transaction: all state returns to reset values immediately (asynchronous). A partially sent frame is abandoned; tx_valid drops at once.
- Latency with tx_ready tied 1 and an instant response: RF_RD accept at cycle 0 -> bytes at cycles 1 and 2 -> WAIT_RSP from cycle 3.

Decomposition:
- Package sys_cmd_pkg holds:
  - command-type encodings;
  - frame opcodes CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD;
  - FSM state enum;
  - frame-length and response-length constants per type.
- The system controller and benches share this package.
- One sub-module: sys_cmd_timer, a loadable/clearable TIMEOUT_W counter with a terminal-count output.

Test Plan:
- RF_WR addr=3, data=0x5A, tx_ready=1 -> tx bytes AA,03,5A on 3 consecutive cycles; rsp_valid 1 cycle later; rsp_data=0; rsp_timeout=0.
- RF_RD addr=2, rx reply 0x81 after 10 cycles -> tx bytes BB,02; rsp_data=0x0081; rsp_timeout=0; busy drops after rsp_valid.
- ALU_OP A=0x10, B=0x20, fun=0; tx_ready toggling 1/0; rx bytes 0x30,0x00 -> tx bytes CC,10,20,00, each held stable while tx_ready=0; rsp_data=0x0030.
- ALU_NOP fun=5, only 1 rx byte 0xEE, TIMEOUT_CYC=100 -> rsp_valid exactly 100 cycles after that byte; rsp_timeout=1; rsp_data=0x00EE.
- Stray rx_valid in IDLE, then RST low during the second tx byte of ALU_OP -> outputs return to reset values within the same cycle; next RF_RD runs normally.
- rx_valid coincident with timer terminal count on the first of 2 response bytes -> no timeout; counter restarts; second byte completes with rsp_timeout=0.
